// File: rtl/count_checker_pkg.sv
// Shared types and defaults for the count sequence checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package count_checker_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int DEF_WIDTH         = 4;
    localparam int DEF_LOCK_COUNT    = 3;
    localparam int DEF_ERR_CNT_WIDTH = 8;

    // Bits needed to hold a match count in 0..lock_count.
    function automatic int match_cnt_width(input int lock_count);
        return (lock_count < 1) ? 1 : $clog2(lock_count + 1);
    endfunction

endpackage

// File: rtl/count_checker_if.sv
// Bundle of the sampled count stream and the checker status outputs.
// Latency: n/a (wires only).
// Backpressure: none; the stream is sampled only on io_in_valid, never stalled.
//   master: drives io_in/io_in_valid/io_clear, observes status.
//   slave : the checker; consumes the stream, drives status.
interface count_checker_if import count_checker_pkg::*; #(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int ERR_CNT_WIDTH = DEF_ERR_CNT_WIDTH
);
    logic [WIDTH-1:0]         io_in;
    logic                     io_in_valid;
    logic                     io_clear;
    logic                     io_locked;
    logic                     io_error;
    logic [ERR_CNT_WIDTH-1:0] io_errCount;
    logic [WIDTH-1:0]         io_expected;

    modport master (
        output io_in, io_in_valid, io_clear,
        input  io_locked, io_error, io_errCount, io_expected
    );

    modport slave (
        input  io_in, io_in_valid, io_clear,
        output io_locked, io_error, io_errCount, io_expected
    );
endinterface

// File: rtl/count_checker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Latency: 1 cycle from inc/clr to count.
// Backpressure: none; holds at all-ones instead of wrapping.
//   clock, reset (sync, active-high), inc, clr in; count out.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/count_checker.sv
// Checks that each valid sample of a count stream is the previous sample +1
// (mod 2^WIDTH); reports lock, one-cycle error pulses and a saturating tally.
// Latency: 1 cycle, all outputs registered. Backpressure: none, invalid cycles hold state.
//   clock, reset (sync, active-high); bus (slave): io_in/io_in_valid/io_clear in,
//   io_locked/io_error/io_errCount/io_expected out.
module count_checker import count_checker_pkg::*; #(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int LOCK_COUNT    = DEF_LOCK_COUNT,
    parameter int ERR_CNT_WIDTH = DEF_ERR_CNT_WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    count_checker_if.slave bus
);
    localparam int MCW = match_cnt_width(LOCK_COUNT);

    state_t                   state;
    logic [MCW-1:0]           match_cnt;
    logic [WIDTH-1:0]         expected;
    logic                     locked;
    logic                     error;
    logic [WIDTH-1:0]         next_exp;
    logic                     in_match;
    logic                     lock_mismatch;
    logic [ERR_CNT_WIDTH-1:0] err_count;

    // Wrap of all-ones to zero falls out of the WIDTH-bit add.
    assign next_exp      = bus.io_in + WIDTH'(1);
    assign in_match      = (bus.io_in == expected);
    assign lock_mismatch = bus.io_in_valid && (state == LOCKED) && !in_match;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            match_cnt <= '0;
            expected  <= '0;
            locked    <= 1'b0;
            error     <= 1'b0;
        end else begin
            error <= 1'b0;
            if (bus.io_in_valid) begin
                // Every valid sample becomes the new reference, match or not.
                expected <= next_exp;
                case (state)
                    IDLE: begin
                        match_cnt <= '0;
                        state     <= ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (!in_match) begin
                            match_cnt <= '0;
                        end else if (match_cnt == MCW'(LOCK_COUNT - 1)) begin
                            match_cnt <= '0;
                            state     <= LOCKED;
                            locked    <= 1'b1;
                        end else begin
                            match_cnt <= match_cnt + MCW'(1);
                        end
                    end
                    LOCKED: begin
                        if (!in_match) begin
                            // Lock drops in the same cycle the error pulse rises.
                            error     <= 1'b1;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                            state     <= ACQUIRE;
                        end
                    end
                    default: begin
                        match_cnt <= '0;
                        locked    <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(ERR_CNT_WIDTH)) u_err_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (lock_mismatch),
        .clr   (bus.io_clear),
        .count (err_count)
    );

    assign bus.io_locked   = locked;
    assign bus.io_error    = error;
    assign bus.io_errCount = err_count;
    assign bus.io_expected = expected;

endmodule

// File: tb/tb_count_checker.sv
// Randomised + directed scoreboard bench for count_checker.
// Latency: expectations are queued at each active edge, compared on the next falling edge.
// Backpressure: none.
module tb_count_checker;
    localparam int W    = 4;
    localparam int LC   = 3;
    localparam int EW   = 2;
    localparam int MODV = 1 << W;
    localparam int EMAX = (1 << EW) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    count_checker_if #(.WIDTH(W), .ERR_CNT_WIDTH(EW)) bus ();

    count_checker #(.WIDTH(W), .LOCK_COUNT(LC), .ERR_CNT_WIDTH(EW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int lock;
        int err;
        int cnt;
        int exp;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    // Reference model: a stream is locked once it has seen at least LC
    // consecutive +1 steps since its last seed (first sample or a break).
    bit seeded = 0;
    int run    = 0;
    int m_exp  = 0;
    int m_cnt  = 0;
    int m_err  = 0;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at t=%0t", name, act, want, $time);
        end
    endtask

    // Monitor: one expectation per active edge, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("locked",   int'(bus.io_locked),   e.lock);
                chk("error",    int'(bus.io_error),    e.err);
                chk("errCount", int'(bus.io_errCount), e.cnt);
                chk("expected", int'(bus.io_expected), e.exp);
            end
        end
    end

    task automatic step(input bit rst, input bit vld, input bit clr, input int val);
        exp_t e;
        reset           = rst;
        bus.io_in_valid = vld;
        bus.io_clear    = clr;
        bus.io_in       = W'(val);
        @(posedge clock);
        if (rst) begin
            seeded = 0; run = 0; m_exp = 0; m_cnt = 0; m_err = 0;
        end else begin
            m_err = 0;
            if (vld) begin
                if (seeded && ((val % MODV) == m_exp)) begin
                    run++;
                end else begin
                    if (seeded && run >= LC) begin
                        m_err = 1;
                        if (m_cnt < EMAX) m_cnt++;
                    end
                    run = 0;
                end
                seeded = 1;
                m_exp  = (val + 1) % MODV;
            end
            if (clr) m_cnt = 0;
        end
        e.lock = (seeded && run >= LC) ? 1 : 0;
        e.err  = m_err;
        e.cnt  = m_cnt;
        e.exp  = m_exp;
        sb.push_back(e);
        #1;
    endtask

    task automatic send(input int val);
        step(1'b0, 1'b1, 1'b0, val % MODV);
    endtask

    initial begin
        int v;
        bit r, vl, cl;
        int x;
        bus.io_in = '0; bus.io_in_valid = 1'b0; bus.io_clear = 1'b0;

        // Reset, then lock-up on 0,1,2,3.
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 5);
        for (int i = 0; i < 4; i++) send(i);
        // Run on up to the wrap 13,14,15,0,1.
        for (int i = 4; i < 18; i++) send(i);
        // Expecting 2: walk to expecting 7, then mismatch with 5, relock on 6,7,8.
        for (int i = 2; i < 7; i++) send(i);
        send(5);
        send(6); send(7); send(8);

        // Valid gaps: idle cycles carrying 9 are ignored.
        step(1'b1, 1'b0, 1'b0, 0);
        send(0); send(1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 9);
        send(2); send(3);

        // Saturation: five lock/mismatch rounds, then clear with a sixth mismatch.
        for (int k = 0; k < 6; k++) begin
            v = int'($urandom_range(0, MODV - 1));
            for (int i = 0; i < 4; i++) send(v + i);
            step(1'b0, 1'b1, (k == 5), (v + 9) % MODV);
        end
        step(1'b0, 1'b0, 1'b0, 0);

        // Reset mid-lock at expected 10, then reseed with 10.
        for (int i = 6; i < 10; i++) send(i);
        step(1'b1, 1'b0, 1'b0, 0);
        send(10); send(11);

        // Random traffic biased toward in-sequence values.
        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(0, 99) < 1);
            vl = ($urandom_range(0, 99) < 75);
            cl = ($urandom_range(0, 99) < 3);
            x  = ($urandom_range(0, 99) < 85) ? m_exp : int'($urandom_range(0, MODV - 1));
            step(r, vl, cl, x);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clock);
        #1;
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0 pending expectations", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
